// File: rtl/regfile_sequencer.sv
// Register-file initiator: accepts one three-operand instruction, reads L/R, executes, writes back on O.
// Optional immediate right operand (in_imm, in_use_imm) is enabled by defining SEQ_IMM_EN.
module regfile_sequencer #(
  parameter int WIDTH     = 16,
  parameter int REG_WIDTH = 3
) (
  input  logic                 clk,
  input  logic                 res,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2:0]           in_op,
  input  logic [REG_WIDTH-1:0] in_dst,
  input  logic [REG_WIDTH-1:0] in_src1,
  input  logic [REG_WIDTH-1:0] in_src2,
`ifdef SEQ_IMM_EN
  input  logic [WIDTH-1:0]     in_imm,
  input  logic                 in_use_imm,
`endif
  output logic [REG_WIDTH-1:0] lSel,
  output logic                 LOUT,
  output logic [REG_WIDTH-1:0] rSel,
  output logic                 ROUT,
  input  logic [WIDTH-1:0]     l,
  input  logic [WIDTH-1:0]     r,
  output logic [REG_WIDTH-1:0] oSel,
  output logic                 OIN,
  output logic [WIDTH-1:0]     o,
  output logic                 done,
  output logic                 flag_z,
  output logic                 flag_c
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    EXEC  = 2'd2,
    WRITE = 2'd3
  } state_t;

  state_t                 state_reg, state_next;
  logic [2:0]             op_reg;
  logic [REG_WIDTH-1:0]   dst_reg, src1_reg, src2_reg;
  logic [WIDTH-1:0]       result_reg;
  logic                   z_reg, c_reg;
  logic [WIDTH-1:0]       operand_b;
  logic [WIDTH-1:0]       alu_res;
  logic                   alu_c;
  logic [WIDTH:0]         alu_wide;
  logic                   accept;

`ifdef SEQ_IMM_EN
  logic                   use_imm_reg;
  logic [WIDTH-1:0]       imm_reg;
  assign operand_b = use_imm_reg ? imm_reg : r;
`else
  assign operand_b = r;
`endif

  assign accept = (state_reg == IDLE) && in_valid;

  always_ff @(posedge clk) begin
    if (res) begin
      state_reg  <= IDLE;
      op_reg     <= '0;
      dst_reg    <= '0;
      src1_reg   <= '0;
      src2_reg   <= '0;
      result_reg <= '0;
      z_reg      <= 1'b0;
      c_reg      <= 1'b0;
`ifdef SEQ_IMM_EN
      use_imm_reg <= 1'b0;
      imm_reg     <= '0;
`endif
    end else begin
      state_reg <= state_next;
      if (accept) begin
        op_reg   <= in_op;
        dst_reg  <= in_dst;
        src1_reg <= in_src1;
        src2_reg <= in_src2;
`ifdef SEQ_IMM_EN
        use_imm_reg <= in_use_imm;
        imm_reg     <= in_imm;
`endif
      end
      // l/r are the registered read data launched in READ, so they are valid now
      if (state_reg == EXEC) begin
        result_reg <= alu_res;
        z_reg      <= (alu_res == '0);
        c_reg      <= alu_c;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    LOUT       = 1'b0;
    ROUT       = 1'b0;
    OIN        = 1'b0;
    done       = 1'b0;
    case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = READ;
      end
      READ: begin
        LOUT = 1'b1;
`ifdef SEQ_IMM_EN
        ROUT = !use_imm_reg;
`else
        ROUT = 1'b1;
`endif
        state_next = EXEC;
      end
      EXEC: state_next = WRITE;
      WRITE: begin
        OIN        = 1'b1;
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    alu_wide = '0;
    alu_res  = '0;
    alu_c    = 1'b0;
    case (op_reg)
      3'b000: begin
        alu_wide = {1'b0, l} + {1'b0, operand_b};
        alu_res  = alu_wide[WIDTH-1:0];
        alu_c    = alu_wide[WIDTH];
      end
      3'b001: begin
        // top bit of the widened difference is the borrow
        alu_wide = {1'b0, l} - {1'b0, operand_b};
        alu_res  = alu_wide[WIDTH-1:0];
        alu_c    = alu_wide[WIDTH];
      end
      3'b010: alu_res = l & operand_b;
      3'b011: alu_res = l | operand_b;
      3'b100: alu_res = l ^ operand_b;
      3'b101: alu_res = l;
      3'b110: begin
        alu_res = {l[WIDTH-2:0], 1'b0};
        alu_c   = l[WIDTH-1];
      end
      default: begin
        alu_res = {1'b0, l[WIDTH-1:1]};
        alu_c   = l[0];
      end
    endcase
  end

  assign lSel   = src1_reg;
  assign rSel   = src2_reg;
  assign oSel   = dst_reg;
  assign o      = result_reg;
  assign flag_z = z_reg;
  assign flag_c = c_reg;

endmodule
